// File: rtl/maxpool_l1.sv
// 2x2 stride-2 max pool of a 64x64 signed 4.16 map into a 32x32 map.
// Optional MAXPOOL_CEIL_EN rounds each pooled max up to an integer, saturating.
module maxpool_l1 #(
  parameter logic [2:0] SRC_SEL = 3'b001,
  parameter logic [2:0] DST_SEL = 3'b011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic [2:0]  csel
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, RDL, WR, FIN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  wx_q, wx_d, wy_q, wy_d;
  logic [19:0] max_q, max_d;
  logic [19:0] wr_val;
  logic        greater;

  // Strictly greater so a tie keeps the value read first.
  assign greater = $signed(cdata_rd) > $signed(max_q);

`ifdef MAXPOOL_CEIL_EN
  always_comb begin
    wr_val = max_q;
    if (max_q[15:0] != 16'h0) begin
      if (max_q[19:16] == 4'h7) wr_val = 20'h7FFFF;
      else                      wr_val = {max_q[19:16] + 4'h1, 16'h0};
    end
  end
`else
  assign wr_val = max_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wx_q    <= '0;
      wy_q    <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      max_q   <= max_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wx_d     = wx_q;
    wy_d     = wy_q;
    max_d    = max_q;
    busy     = 1'b0;
    done     = 1'b0;
    crd      = 1'b0;
    cwr      = 1'b0;
    caddr_rd = 12'h0;
    caddr_wr = 12'h0;
    cdata_wr = 20'h0;
    csel     = 3'b000;
    // Read address bit 6 picks the window row, bit 0 the window column.
    case (state_q)
      IDLE: if (start) state_d = RD0;
      RD0: begin
        busy     = 1'b1;
        crd      = 1'b1;
        csel     = SRC_SEL;
        caddr_rd = {wy_q, 1'b0, wx_q, 1'b0};
        state_d  = RD1;
      end
      RD1: begin
        busy     = 1'b1;
        crd      = 1'b1;
        csel     = SRC_SEL;
        caddr_rd = {wy_q, 1'b0, wx_q, 1'b1};
        max_d    = cdata_rd;
        state_d  = RD2;
      end
      RD2: begin
        busy     = 1'b1;
        crd      = 1'b1;
        csel     = SRC_SEL;
        caddr_rd = {wy_q, 1'b1, wx_q, 1'b0};
        if (greater) max_d = cdata_rd;
        state_d  = RD3;
      end
      RD3: begin
        busy     = 1'b1;
        crd      = 1'b1;
        csel     = SRC_SEL;
        caddr_rd = {wy_q, 1'b1, wx_q, 1'b1};
        if (greater) max_d = cdata_rd;
        state_d  = RDL;
      end
      RDL: begin
        busy    = 1'b1;
        if (greater) max_d = cdata_rd;
        state_d = WR;
      end
      WR: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        csel     = DST_SEL;
        caddr_wr = {2'b00, wy_q, wx_q};
        cdata_wr = wr_val;
        state_d  = RD0;
        if (wx_q == 5'd31) begin
          wx_d = 5'd0;
          if (wy_q == 5'd31) begin
            wy_d    = 5'd0;
            state_d = FIN;
          end else begin
            wy_d = wy_q + 5'd1;
          end
        end else begin
          wx_d = wx_q + 5'd1;
        end
      end
      FIN: begin
        done    = 1'b1;
        wx_d    = 5'd0;
        wy_d    = 5'd0;
        max_d   = 20'h0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/maxpool_l1.md
MAXPOOL_L1 -- requirements
Module: maxpool_l1

Interface
REQ-001 Parameter SRC_SEL, default 3'b001, csel value driven during source (layer-0 map) reads.
REQ-002 Parameter DST_SEL, default 3'b011, csel value driven during destination (layer-1 map) writes.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to pool the complete 64x64 source map.
REQ-006 busy  output  1  high from the cycle after start is accepted until done.
REQ-007 done  output  1  one-cycle pulse after the final write.
REQ-008 crd  output  1  source read strobe.
REQ-009 caddr_rd  output  12  source read address, row-major, 64 words per row.
REQ-010 cdata_rd  input  20  source read data, signed 4.16 fixed point.
REQ-011 cwr  output  1  destination write strobe.
REQ-012 caddr_wr  output  12  destination write address, row-major, 32 words per row, range 0..1023.
REQ-013 cdata_wr  output  20  destination write data, signed 4.16 fixed point.
REQ-014 csel  output  3  memory select: SRC_SEL while crd=1, DST_SEL while cwr=1, 3'b000 otherwise.

Function
REQ-015 The block SHALL compute a 2x2, stride-2 max pool of the 64x64 source map into a 32x32 destination map.
REQ-016 For window (wy,wx), wy,wx in 0..31, the read addresses SHALL be base=wy*128+wx*2, then base+1, base+64, base+65, in that order.
REQ-017 The write address for window (wy,wx) SHALL be wy*32+wx.
REQ-018 Windows SHALL be processed in raster order: wx increments first, and wx wraps from 31 to 0 while wy increments.
REQ-019 Read latency: cdata_rd SHALL be sampled on the rising edge that ends the cycle following the cycle in which crd was high.
REQ-020 FSM states SHALL be IDLE, RD0, RD1, RD2, RD3, RDL, WR and FIN.
REQ-021 IDLE -> RD0 when start=1; start SHALL be ignored in every other state.
REQ-022 RD0..RD3 SHALL each assert crd with the corresponding address; RD1, RD2, RD3 and RDL SHALL capture the data returned by the preceding read.
REQ-023 The comparison SHALL be a signed 20-bit running max; on equal values the earlier-read value SHALL be kept.
REQ-024 WR SHALL assert cwr for exactly one cycle, driving cdata_wr and caddr_wr; crd and cwr SHALL never be high in the same cycle.
REQ-025 WR -> RD0 for the next window; WR -> FIN after window (31,31).
REQ-026 Each window SHALL take exactly 6 cycles (RD0..WR), so one job takes 6144 cycles from RD0 entry to the last WR.
REQ-027 FIN SHALL pulse done=1 and drop busy in the same cycle, then return to IDLE; the window counters SHALL be cleared for the next job.
REQ-028 start arriving in the FIN cycle SHALL be ignored.
REQ-029 busy SHALL rise in the cycle after start is sampled in IDLE, i.e. in the RD0 cycle.

Reset
REQ-030 Reset SHALL force the FSM to IDLE and clear the window counters and the running max.
REQ-031 Reset SHALL drive busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr and csel to 0.
REQ-032 Reset asserted mid-job SHALL abort the job with no further reads or writes; a later start SHALL restart from window (0,0).

Configuration
REQ-033 The block SHALL support compile-time macro MAXPOOL_CEIL_EN.
REQ-034 With MAXPOOL_CEIL_EN defined, the written value SHALL be the pooled max rounded up to an integer:
- if bits [15:0] are nonzero, clear bits [15:0] and add 20'h10000;
- if the result would exceed 20'h7FFFF, saturate to 20'h7FFFF;
- negative values SHALL round toward +infinity.
REQ-035 With MAXPOOL_CEIL_EN undefined, the pooled max SHALL be written unchanged.

Verification
REQ-036 Source map with every word 20'h12345, macro undefined -> 1024 writes of 20'h12345, addresses 0..1023 in order, single done pulse.
REQ-037 Source word[a]=a (zero-extended address) -> write k=wy*32+wx carries base+65; first read addresses 0,1,64,65; last write addr 1023 data 4095.
REQ-038 MAXPOOL_CEIL_EN defined, window (0,0) = {20'h18000, 20'h10000, 20'h00001, 20'h0FFFF} -> caddr_wr 0 receives 20'h20000; a window of all 20'h7C000 -> 20'h7FFFF (saturated).
REQ-039 Window (0,0) = {20'hF0000, 20'hE8000, 20'hF8000, 20'hFFFFF}, macro undefined -> 20'hFFFFF; macro defined -> 20'h00000.
REQ-040 start pulsed again at cycle 100 of a job -> ignored, still exactly 1024 writes; done asserted 6144 cycles after RD0 entry plus one FIN cycle.
REQ-041 reset asserted after 300 writes -> all outputs 0 the same cycle, no further strobes; a new start gives a first read at address 0 and 1024 writes.
